// File: rtl/rotate_share_arbiter.sv
// Two requesters share one 8-bit rotate-left unit; ROT_ARB_STATS_EN adds saturating per-requester grant counters.
// Accept at edge N -> rsp_valid after edge N+1; one op in flight, readies stay low until the response is taken.
module rotate_share_arbiter #(
  parameter int RR    = 1,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic [2:0] req0_amt,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic [2:0] req1_amt,
  output logic       req1_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_id,
  input  logic       rsp_ready,
  output logic       busy
`ifdef ROT_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] amt;
    logic       id;
  } op_t;

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic        last_grant;
  logic        pick1;
  logic        accept;
  logic [15:0] rot_wide;
  logic [7:0]  rot;

  // Rotating a doubled copy left leaves the wrapped bits in the upper byte.
  assign rot_wide = {op_q.data, op_q.data} << op_q.amt;
  assign rot      = rot_wide[15:8];
  assign busy     = (state_q != IDLE);
  assign op_d     = pick1 ? {req1_data, req1_amt, 1'b1} : {req0_data, req0_amt, 1'b0};

  always_comb begin
    state_d    = state_q;
    pick1      = 1'b0;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (req0_valid && req1_valid)
      pick1 = (RR != 0) ? ~last_grant : 1'b0;
    else
      pick1 = req1_valid;
    case (state_q)
      IDLE: begin
        if ((req0_valid || req1_valid) && !reset) begin
          accept     = 1'b1;
          req0_ready = ~pick1;
          req1_ready = pick1;
          state_d    = CALC;
        end
      end
      CALC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= '0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
      rsp_id     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q       <= op_d;
        last_grant <= pick1;
      end
      if (state_q == CALC) begin
        rsp_data  <= rot;
        rsp_id    <= op_q.id;
        rsp_valid <= 1'b1;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ROT_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (accept) begin
      if (!pick1 && gnt_cnt0 != '1) gnt_cnt0 <= gnt_cnt0 + 1'b1;
      if (pick1 && gnt_cnt1 != '1)  gnt_cnt1 <= gnt_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rotate_share_arbiter.sv
// Directed bench for rotate_share_arbiter: main instance RR=1, second instance RR=0 held in a constant tie.
module tb_rotate_share_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic [2:0] req0_amt, req1_amt;
  logic       rsp_valid, rsp_id, rsp_ready, busy;
  logic [7:0] rsp_data;

  logic       f_req0_valid, f_req1_valid, f_req0_ready, f_req1_ready;
  logic [7:0] f_req0_data, f_req1_data;
  logic [2:0] f_req0_amt, f_req1_amt;
  logic       f_rsp_valid, f_rsp_id, f_rsp_ready, f_busy;
  logic [7:0] f_rsp_data;

`ifdef ROT_ARB_STATS_EN
  logic [1:0] gnt_cnt0, gnt_cnt1, f_gnt_cnt0, f_gnt_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rotate_share_arbiter #(.RR(1), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_amt(req0_amt), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_amt(req1_amt), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ready(rsp_ready), .busy(busy)
`ifdef ROT_ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  rotate_share_arbiter #(.RR(0), .CNT_W(2)) dut_fixed (
    .clk(clk), .reset(reset),
    .req0_valid(f_req0_valid), .req0_data(f_req0_data), .req0_amt(f_req0_amt), .req0_ready(f_req0_ready),
    .req1_valid(f_req1_valid), .req1_data(f_req1_data), .req1_amt(f_req1_amt), .req1_ready(f_req1_ready),
    .rsp_valid(f_rsp_valid), .rsp_data(f_rsp_data), .rsp_id(f_rsp_id), .rsp_ready(f_rsp_ready), .busy(f_busy)
`ifdef ROT_ARB_STATS_EN
    , .gnt_cnt0(f_gnt_cnt0), .gnt_cnt1(f_gnt_cnt1)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one op and takes its response; a missed handshake is recorded as a failure.
  task automatic do_op(input logic id, input logic [7:0] d, input logic [2:0] a,
                       output logic [7:0] rd, output logic rid);
    int n;
    rd = 8'h00;
    rid = 1'b0;
    if (id) begin req1_valid = 1'b1; req1_data = d; req1_amt = a; end
    else    begin req0_valid = 1'b1; req0_data = d; req0_amt = a; end
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 10) begin step(); n++; end
    if (n >= 10) begin
      checks++; errors++;
      $display("FAIL do_op_accept: ready never rose for requester %0d", id);
    end
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin step(); n++; end
    if (n >= 10) begin
      checks++; errors++;
      $display("FAIL do_op_rsp: rsp_valid never rose for requester %0d", id);
    end
    rd = rsp_data;
    rid = rsp_id;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 1'b1; req0_data = 8'hAA; req0_amt = 3'd1;
    req1_valid = 1'b0; req1_data = 8'h00; req1_amt = 3'd0;
    rsp_ready = 1'b0;
    step(); step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data: got %h want 00", rsp_data); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id: got %b want 0", rsp_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b want 0", req0_ready); end
    req0_valid = 1'b0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_resp();
    req0_valid = 1'b1; req0_data = 8'h5A; req0_amt = 3'd0;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL mid_accept0: got %b want 1", req0_ready); end
    step();
    req0_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_calc: got %b want 1", busy); end
    step(); step();
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h5A) begin
      errors++; $display("FAIL mid_resp_hold: got %b/%h want 1/5a", rsp_valid, rsp_data); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got %h want 00", rsp_data); end
    req0_valid = 1'b1; req0_data = 8'h81; req0_amt = 3'd1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL mid_reaccept: got %b want 1", req0_ready); end
    step();
    req0_valid = 1'b0;
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h03 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL mid_after_rst_rsp: got %b/%h/%b want 1/03/0", rsp_valid, rsp_data, rsp_id); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_single_req0();
    req0_valid = 1'b1; req0_data = 8'b01111011; req0_amt = 3'd1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL single_ready: got %b%b want 10", req0_ready, req1_ready); end
    step();
    req0_data = 8'h00;
    req0_amt = 3'd5;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL single_ready_drop: got %b want 0", req0_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", rsp_valid); end
    req0_valid = 1'b0;
    step();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_data !== 8'b11110110) begin errors++; $display("FAIL single_data: got %b want 11110110", rsp_data); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_id: got %b want 0", rsp_id); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_release: got %b/%b want 0/0", rsp_valid, busy); end
  endtask

  task automatic test_amt_sweep();
    logic [7:0] exp_tbl [8] = '{8'b01111011, 8'b11110110, 8'b11101101, 8'b11011011,
                                8'b10110111, 8'b01101111, 8'b11011110, 8'b10111101};
    logic [7:0] rd;
    logic       rid;
    for (int i = 0; i < 8; i++) begin
      do_op(1'b1, 8'b01111011, 3'(i), rd, rid);
      checks++; if (rd !== exp_tbl[i]) begin errors++; $display("FAIL sweep_data amt=%0d: got %b want %b", i, rd, exp_tbl[i]); end
      checks++; if (rid !== 1'b1) begin errors++; $display("FAIL sweep_id amt=%0d: got %b want 1", i, rid); end
    end
  endtask

  task automatic test_round_robin();
    int g_cyc [$];
    int g_id  [$];
    int want_id [4] = '{0, 1, 0, 1};
    req0_valid = 1'b1; req0_data = 8'h01; req0_amt = 3'd1;
    req1_valid = 1'b1; req1_data = 8'h80; req1_amt = 3'd1;
    rsp_ready = 1'b1;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (req0_ready) begin g_cyc.push_back(c); g_id.push_back(0); end
      if (req1_ready) begin g_cyc.push_back(c); g_id.push_back(1); end
      if (rsp_valid) begin
        checks++;
        if (rsp_data !== (rsp_id ? 8'h01 : 8'h02)) begin
          errors++; $display("FAIL rr_data cyc=%0d: got %h for id %b", c, rsp_data, rsp_id); end
      end
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    checks++; if (g_id.size() != 4) begin errors++; $display("FAIL rr_count: got %0d want 4", g_id.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (g_id[k] != want_id[k] || g_cyc[k] != 3 * k) begin
          errors++; $display("FAIL rr_grant %0d: got id %0d cyc %0d want id %0d cyc %0d",
                             k, g_id[k], g_cyc[k], want_id[k], 3 * k); end
      end
    end
  endtask

  task automatic test_fixed_priority();
    int c0 = 0;
    int c1 = 0;
    int bad = 0;
    for (int c = 0; c < 12; c++) begin
      if (f_req0_ready) c0++;
      if (f_req1_ready) c1++;
      if (f_rsp_valid && (f_rsp_id !== 1'b0 || f_rsp_data !== 8'h21)) bad++;
      step();
    end
    checks++; if (c0 != 4) begin errors++; $display("FAIL fixed_req0_grants: got %0d want 4", c0); end
    checks++; if (c1 != 0) begin errors++; $display("FAIL fixed_req1_grants: got %0d want 0", c1); end
    checks++; if (bad != 0) begin errors++; $display("FAIL fixed_rsp: got %0d bad responses want 0", bad); end
  endtask

  task automatic test_backpressure();
    req0_valid = 1'b1; req0_data = 8'h3C; req0_amt = 3'd2;
    #1;
    step();
    req1_valid = 1'b1; req1_data = 8'h0F; req1_amt = 3'd4;
    step();
    for (int c = 0; c < 5; c++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hF0 || rsp_id !== 1'b0) begin
        errors++; $display("FAIL bp_hold cyc=%0d: got %b/%h/%b want 1/f0/0", c, rsp_valid, rsp_data, rsp_id); end
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL bp_ready cyc=%0d: got %b%b want 00", c, req0_ready, req1_ready); end
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b want 0", rsp_valid); end
    checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++; $display("FAIL bp_resume: got %b%b want 01", req0_ready, req1_ready); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
  endtask

`ifdef ROT_ARB_STATS_EN
  task automatic test_stats();
    logic [7:0] rd;
    logic       rid;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (gnt_cnt0 !== 2'd0) begin errors++; $display("FAIL stats_reset: got %0d want 0", gnt_cnt0); end
    do_op(1'b0, 8'h01, 3'd0, rd, rid);
    checks++; if (gnt_cnt0 !== 2'd1) begin errors++; $display("FAIL stats_one: got %0d want 1", gnt_cnt0); end
    for (int i = 0; i < 4; i++) do_op(1'b0, 8'h01, 3'd0, rd, rid);
    checks++; if (gnt_cnt0 !== 2'd3) begin errors++; $display("FAIL stats_sat0: got %0d want 3", gnt_cnt0); end
    checks++; if (gnt_cnt1 !== 2'd0) begin errors++; $display("FAIL stats_cnt1: got %0d want 0", gnt_cnt1); end
  endtask
`endif

  initial begin
    f_req0_valid = 1'b1; f_req0_data = 8'h12; f_req0_amt = 3'd4;
    f_req1_valid = 1'b1; f_req1_data = 8'h34; f_req1_amt = 3'd1;
    f_rsp_ready = 1'b1;
    test_reset();
    test_reset_mid_resp();
    test_single_req0();
    test_amt_sweep();
    test_round_robin();
    test_fixed_priority();
    test_backpressure();
`ifdef ROT_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
